// File: rtl/stuff_serializer_pkg.sv
// rtl/stuff_serializer_pkg.sv - shared state encodings and defaults for the stuffing serializer
package stuff_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_MAXRUN = 3;

endpackage

// File: rtl/stuff_run_tracker.sv
// rtl/stuff_run_tracker.sv - run length and last line bit, counted over valid line bits only
module stuff_run_tracker #(
  parameter int MAXRUN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_bit,
  input  logic strobe,
  input  logic is_stuff,
  output logic hit,
  output logic last_bit
);

  localparam int RW = $clog2(MAXRUN + 1);

  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (strobe) begin
      if (is_stuff) begin
        run_d = RW'(1);
      end else if (run_q != '0 && line_bit == last_q) begin
        run_d = run_q + RW'(1);
      end else begin
        run_d = RW'(1);
      end
      last_d = line_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

  assign hit      = (run_q == RW'(MAXRUN));
  assign last_bit = last_q;

endmodule

// File: rtl/stuff_serializer.sv
// rtl/stuff_serializer.sv - MSB-first serializer inserting a stuff bit after MAXRUN equal bits
module stuff_serializer
  import stuff_serializer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int MAXRUN = DEF_MAXRUN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_stuff,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             stuff_q, stuff_d;
  logic             next_data;
  logic             trk_strobe, trk_is_stuff, trk_bit;
  logic             hit, last_bit;

  stuff_run_tracker #(.MAXRUN(MAXRUN)) u_run (
    .clk      (clk),
    .reset    (reset),
    .line_bit (trk_bit),
    .strobe   (trk_strobe),
    .is_stuff (trk_is_stuff),
    .hit      (hit),
    .last_bit (last_bit)
  );

  // The state register names the bit currently on the line; the tracker is
  // strobed at the same edge that loads sout, so hit reflects the shown bit.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = sout_q;
    valid_d      = 1'b0;
    stuff_d      = 1'b0;
    next_data    = 1'b0;
    trk_strobe   = 1'b0;
    trk_is_stuff = 1'b0;
    trk_bit      = sout_q;
    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          state_d    = SHIFT;
          sout_d     = din[WIDTH-1];
          shreg_d    = {din[WIDTH-2:0], 1'b0};
          cnt_d      = CW'(WIDTH - 1);
          valid_d    = 1'b1;
          trk_strobe = 1'b1;
          trk_bit    = din[WIDTH-1];
        end
      end
      SHIFT: begin
        if (hit) begin
          state_d      = STUFF;
          sout_d       = ~last_bit;
          valid_d      = 1'b1;
          stuff_d      = 1'b1;
          trk_strobe   = 1'b1;
          trk_is_stuff = 1'b1;
          trk_bit      = ~last_bit;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          next_data = 1'b1;
        end
      end
      STUFF: begin
        if (cnt_q == '0) state_d = IDLE;
        else             next_data = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (next_data) begin
      state_d    = SHIFT;
      sout_d     = shreg_q[WIDTH-1];
      shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d      = cnt_q - CW'(1);
      valid_d    = 1'b1;
      trk_strobe = 1'b1;
      trk_bit    = shreg_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      stuff_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      stuff_q <= stuff_d;
    end
  end

  assign din_ready  = (state_q == IDLE);
  assign busy       = ~din_ready;
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_stuff = stuff_q;

endmodule
